// File: rtl/sig_debouncer_pkg.sv
// sig_debouncer_pkg: shared types and constants for the level debouncer.
//   state_t    : debouncer FSM states (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO)
//   GLITCH_W   : width of the rejected-change counter
//   GLITCH_MAX : saturation value of the rejected-change counter
`timescale 1ns/1ps
package sig_debouncer_pkg;

   localparam int unsigned GLITCH_W   = 8;
   localparam int unsigned GLITCH_MAX = 255;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

endpackage : sig_debouncer_pkg

// File: rtl/sig_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk : sampling clock
//   rst : asynchronous active-high clear of both flops
//   d   : asynchronous input level
//   q   : synchronized level, two clk edges after d settles
`timescale 1ns/1ps
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; second flop gives it a full cycle to resolve.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : sync_2ff

// File: rtl/sig_debouncer.sv
// sig_debouncer: qualifies a bouncy external level before passing it on.
// A new level must be sampled on STABLE_CYCLES consecutive cycles before
// out_sig follows it; shorter excursions are rejected and counted.
// Build option: define SIG_DEBOUNCER_SYNC_EN to insert a two-flop
// synchronizer ahead of the FSM (latency STABLE_CYCLES+2 edges); leave it
// undefined for already-synchronous sources (latency STABLE_CYCLES edges).
// Ports:
//   clk        : rising-edge clock for all state
//   rst        : asynchronous active-high reset
//   in_raw     : raw input level (button / switch)
//   out_sig    : debounced level (registered)
//   busy       : high while a level change is being qualified (registered)
//   glitch_cnt : saturating count of rejected level changes (registered)
`timescale 1ns/1ps
module sig_debouncer
   import sig_debouncer_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_raw,
   output logic                out_sig,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   // Count value on which one more matching sample completes qualification.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [GLITCH_W-1:0] GLITCH_SAT = GLITCH_W'(GLITCH_MAX);

   logic          s;
   state_t        state;
   state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic          glitch_inc_c;
   logic          out_nxt_c;
   logic          busy_nxt_c;

   // Sampled input source.
`ifdef SIG_DEBOUNCER_SYNC_EN
   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (in_raw),
      .q   (s)
   );
`else
   assign s = in_raw;
`endif

   // State, counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE_LO;
         cnt        <= '0;
         out_sig    <= 1'b0;
         busy       <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         out_sig <= out_nxt_c;
         busy    <= busy_nxt_c;
         if (glitch_inc_c && (glitch_cnt != GLITCH_SAT)) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
         end
      end
   end

   // Next-state, counter and next-output logic.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      glitch_inc_c = 1'b0;

      case (state)
         IDLE_LO: begin
            if (s) begin
               // With a single required sample the first differing one qualifies.
               if (STABLE_CYCLES == 1) begin
                  state_nxt = IDLE_HI;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = WAIT_HI;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end

         WAIT_HI: begin
            if (s) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = IDLE_HI;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               state_nxt    = IDLE_LO;
               cnt_nxt      = '0;
               glitch_inc_c = 1'b1;
            end
         end

         IDLE_HI: begin
            if (!s) begin
               if (STABLE_CYCLES == 1) begin
                  state_nxt = IDLE_LO;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = WAIT_LO;
                  cnt_nxt   = CNT_W'(1);
               end
            end
         end

         WAIT_LO: begin
            if (!s) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = IDLE_LO;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               state_nxt    = IDLE_HI;
               cnt_nxt      = '0;
               glitch_inc_c = 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE_LO;
            cnt_nxt   = '0;
         end
      endcase

      // Outputs are a function of the next state so the flops mirror the FSM.
      out_nxt_c  = (state_nxt == IDLE_HI) || (state_nxt == WAIT_LO);
      busy_nxt_c = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
   end

endmodule : sig_debouncer
